// File: rtl/spam_master_pkg.sv
// Shared SPAM bus widths, device IDs and the initiator state type.
package spam_master_pkg;

  localparam int SPAM_DID_HI  = 3;
  localparam int SPAM_ADDR_HI = 23;
  localparam int SPAM_DATA_HI = 31;

  localparam int unsigned SPAM_TIMEOUT_DEFAULT = 4096;

  localparam logic [SPAM_DID_HI:0] SPAM_DID_SACE = 4'h1;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_UART = 4'h2;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_GPIO = 4'h3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } spam_state_e;

  typedef struct packed {
    logic                    r_nw;
    logic [SPAM_DID_HI:0]    did;
    logic [SPAM_ADDR_HI:0]   addr;
    logic [SPAM_DATA_HI:0]   data;
  } spam_req_t;

endpackage

// File: rtl/spam_master_if.sv
// Core request/response port plus SPAM command and response buses of one initiator.
interface spam_master_if;
  import spam_master_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_r_nw;
  logic [SPAM_DID_HI:0]  req_did;
  logic [SPAM_ADDR_HI:0] req_addr;
  logic [SPAM_DATA_HI:0] req_data;

  logic                  rsp_valid;
  logic [SPAM_DATA_HI:0] rsp_data;
  logic                  rsp_err;

  logic                  spamo_valid;
  logic                  spamo_r_nw;
  logic [SPAM_DID_HI:0]  spamo_did;
  logic [SPAM_ADDR_HI:0] spamo_addr;
  logic [SPAM_DATA_HI:0] spamo_data;

  logic                  spami_busy_b;
  logic [SPAM_DATA_HI:0] spami_data;

  logic                  stray_rsp;

  modport master (
    input  req_valid, req_r_nw, req_did, req_addr, req_data, spami_busy_b, spami_data,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data, stray_rsp
  );

  modport slave (
    output req_valid, req_r_nw, req_did, req_addr, req_data, spami_busy_b, spami_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data, stray_rsp
  );

endinterface

// File: rtl/spam_timeout_ctr.sv
// 16-bit clear/increment counter flagging when it sits at the abandon limit.
module spam_timeout_ctr #(
  parameter logic [15:0] Limit = 16'd4095
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = (r_cnt == Limit);

endmodule

// File: rtl/spam_master.sv
// Single-outstanding SPAM initiator: one strobe per request, then wait for the
// OR-combined completion pulse or give up after TIMEOUT cycles.
module spam_master
  import spam_master_pkg::*;
#(
  parameter int unsigned        TIMEOUT  = SPAM_TIMEOUT_DEFAULT,
  parameter logic [31:0]        ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  spam_master_if.master bus
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  spam_state_e           r_state, w_state_d;
  spam_req_t             r_req;
  logic [SPAM_DATA_HI:0] r_rsp_data, w_cap_data;
  logic                  r_rsp_err, w_cap_err, w_capture;
  logic                  r_stray, r_req_ready, r_spamo_valid, r_rsp_valid;
  logic                  w_ctr_clr, w_ctr_inc, w_expired;

  spam_timeout_ctr #(
    .Limit(LIMIT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_ctr_clr),
    .i_inc    (w_ctr_inc),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_d  = r_state;
    w_ctr_clr  = 1'b0;
    w_ctr_inc  = 1'b0;
    w_capture  = 1'b0;
    w_cap_data = '0;
    w_cap_err  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ctr_clr = 1'b1;
        if (bus.req_valid) w_state_d = StIssue;
      end
      StIssue: begin
        w_ctr_clr = 1'b1;
        w_state_d = StWait;
      end
      StWait: begin
        // A pulse on the expiry cycle still counts as a normal completion.
        if (bus.spami_busy_b) begin
          w_capture  = 1'b1;
          w_cap_data = r_req.r_nw ? bus.spami_data : '0;
          w_state_d  = StResp;
        end else if (w_expired) begin
          w_capture  = 1'b1;
          w_cap_data = ERR_DATA;
          w_cap_err  = 1'b1;
          w_state_d  = StResp;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_req         <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_stray       <= 1'b0;
      r_req_ready   <= 1'b1;
      r_spamo_valid <= 1'b0;
      r_rsp_valid   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && bus.req_valid) begin
        r_req <= '{r_nw: bus.req_r_nw, did: bus.req_did, addr: bus.req_addr,
                   data: bus.req_data};
      end
      if (w_capture) begin
        r_rsp_data <= w_cap_data;
        r_rsp_err  <= w_cap_err;
      end
      if (bus.spami_busy_b && r_state != StWait) r_stray <= 1'b1;
      r_req_ready   <= (w_state_d == StIdle);
      r_spamo_valid <= (w_state_d == StIssue);
      r_rsp_valid   <= (w_state_d == StResp);
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.spamo_valid = r_spamo_valid;
  assign bus.spamo_r_nw  = r_req.r_nw;
  assign bus.spamo_did   = r_req.did;
  assign bus.spamo_addr  = r_req.addr;
  assign bus.spamo_data  = r_req.data;
  assign bus.stray_rsp   = r_stray;

endmodule

// File: tb/tb_spam_master.sv
// Directed bench for spam_master with a cycle-timeline reference model and a reactive device.
module tb_spam_master;
  import spam_master_pkg::*;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spam_master_if bus ();

  spam_master #(
    .TIMEOUT (TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction accepted at cycle t0 strobes at t0+1, listens from t0+2
  // through t0+1+TO, responds the cycle after the first pulse (or at t0+2+TO).
  bit          m_active = 1'b0, m_err = 1'b0, m_stray = 1'b0, m_after_rst = 1'b0, in_win;
  int          m_t0 = 0, m_rsp = -1;
  logic        m_rnw = 1'b0;
  logic [3:0]  m_did = '0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_rsp = -1; m_stray = 1'b0; m_after_rst = 1'b1;
      m_rnw = 1'b0; m_did = '0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    end else begin
      m_after_rst = 1'b0;
      in_win = m_active && m_rsp < 0 && cyc >= m_t0 + 2;
      if (bus.spami_busy_b && !in_win) m_stray = 1'b1;
      if (in_win && bus.spami_busy_b) begin
        m_rsp = cyc + 1; m_rdata = m_rnw ? bus.spami_data : 32'h0; m_err = 1'b0;
      end else if (in_win && cyc == m_t0 + 1 + int'(TO)) begin
        m_rsp = cyc + 1; m_rdata = ERR; m_err = 1'b1;
      end
      if (m_active && cyc == m_rsp) begin
        m_active = 1'b0;
      end else if (!m_active && bus.req_valid) begin
        m_active = 1'b1; m_t0 = cyc; m_rsp = -1;
        m_rnw = bus.req_r_nw; m_did = bus.req_did; m_addr = bus.req_addr;
        m_wdata = bus.req_data;
      end
    end
    cyc++;
  end

  bit e_sv, e_rv;
  int strobes[$];
  logic [31:0] strobe_data = '0;
  int rsp_cnt = 0;

  always @(negedge clk) begin
    e_sv = m_active && cyc == m_t0 + 1;
    e_rv = m_active && cyc == m_rsp;
    chk1("req_ready", bus.req_ready, !m_active);
    chk1("spamo_valid", bus.spamo_valid, e_sv);
    chk1("rsp_valid", bus.rsp_valid, e_rv);
    chk1("stray_rsp", bus.stray_rsp, m_stray);
    if (e_sv || m_after_rst || (m_active && m_rsp < 0 && cyc >= m_t0 + 2)) begin
      chk1("spamo_r_nw", bus.spamo_r_nw, m_rnw);
      chk("spamo_did", 32'(bus.spamo_did), 32'(m_did));
      chk("spamo_addr", 32'(bus.spamo_addr), 32'(m_addr));
      chk("spamo_data", bus.spamo_data, m_wdata);
    end
    if (e_rv || m_after_rst) begin
      chk("rsp_data", bus.rsp_data, m_rdata);
      chk1("rsp_err", bus.rsp_err, m_err);
    end
    if (bus.spamo_valid) begin
      strobes.push_back(cyc);
      strobe_data = bus.spamo_data;
    end
    if (bus.rsp_valid) rsp_cnt++;
  end

  // Device: pulses dev_delay cycles after the strobe cycle; man_req injects one pulse.
  int          dev_delay = 0, dev_pend = 0;
  logic [31:0] dev_rdata = '0, man_data = '0;
  bit          man_req = 1'b0;

  always @(posedge clk) begin
    #1;
    bus.spami_busy_b = 1'b0;
    bus.spami_data   = '0;
    if (dev_pend > 0) begin
      dev_pend--;
      if (dev_pend == 0) begin
        bus.spami_busy_b = 1'b1;
        bus.spami_data   = dev_rdata;
      end
    end
    if (man_req) begin
      bus.spami_busy_b = 1'b1;
      bus.spami_data   = man_data;
      man_req = 1'b0;
    end
    if (bus.spamo_valid && dev_delay > 0) dev_pend = dev_delay;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rnw, input logic [3:0] did, input logic [23:0] addr,
                       input logic [31:0] data, output int n);
    bit got = 1'b0;
    n = -1;
    bus.req_r_nw = rnw; bus.req_did = did; bus.req_addr = addr; bus.req_data = data;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        n = cyc;
      end
    end
    if (!got) chk1("accept_bound", 1'b0, 1'b1);
    step(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int m, output logic [31:0] d, output logic e);
    bit got = 1'b0;
    m = -1; d = '0; e = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1; m = cyc; d = bus.rsp_data; e = bus.rsp_err;
      end
    end
    if (!got) chk1("rsp_bound", 1'b0, 1'b1);
    step(1);
  endtask

  int n, m;
  int acc[3];
  logic [31:0] d;
  logic e;

  initial begin
    bus.req_valid = 1'b0; bus.req_r_nw = 1'b0; bus.req_did = '0;
    bus.req_addr = '0; bus.req_data = '0;
    bus.spami_busy_b = 1'b0; bus.spami_data = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_ready", bus.req_ready, 1'b1);
    chk1("reset_stray", bus.stray_rsp, 1'b0);
    step(1);

    // Read, device answers four cycles after the strobe
    dev_delay = 4; dev_rdata = 32'h0000_1234; strobes.delete();
    issue(1'b1, SPAM_DID_SACE, 24'h000010, 32'h0, n);
    wait_rsp(m, d, e);
    chk("rd_strobe_cnt", 32'(strobes.size()), 32'd1);
    if (strobes.size() > 0) chk("rd_strobe_cyc", strobes[0], n + 1);
    chk("rd_rsp_cyc", m, n + 6);
    chk("rd_data", d, 32'h0000_1234);
    chk1("rd_err", e, 1'b0);
    step(2);

    // Write, device drives garbage data with its pulse
    dev_delay = 3; dev_rdata = 32'hDEAD_BEEF;
    issue(1'b0, SPAM_DID_UART, 24'h000020, 32'h0000_A5A5, n);
    wait_rsp(m, d, e);
    chk("wr_strobe_data", strobe_data, 32'h0000_A5A5);
    chk("wr_rsp_cyc", m, n + 5);
    chk("wr_data", d, 32'h0);
    chk1("wr_err", e, 1'b0);
    step(2);

    // Timeout, then a late pulse, then a normal read
    dev_delay = 0;
    issue(1'b1, SPAM_DID_GPIO, 24'h000100, 32'h0, n);
    wait_rsp(m, d, e);
    chk("to_rsp_cyc", m, n + 10);
    chk("to_data", d, 32'hFFFF_FFFF);
    chk1("to_err", e, 1'b1);
    man_data = 32'h0000_0077; man_req = 1'b1;
    step(3);
    @(negedge clk);
    chk1("late_stray", bus.stray_rsp, 1'b1);
    step(1);
    dev_delay = 2; dev_rdata = 32'hCAFE_0001;
    issue(1'b1, SPAM_DID_SACE, 24'h000004, 32'h0, n);
    wait_rsp(m, d, e);
    chk("post_to_rsp_cyc", m, n + 4);
    chk("post_to_data", d, 32'hCAFE_0001);
    chk1("post_to_err", e, 1'b0);
    step(2);

    // Pulse lands on the expiry cycle
    dev_delay = int'(TO); dev_rdata = 32'h0BAD_F00D;
    issue(1'b1, SPAM_DID_SACE, 24'h000008, 32'h0, n);
    wait_rsp(m, d, e);
    chk("coin_rsp_cyc", m, n + 10);
    chk("coin_data", d, 32'h0BAD_F00D);
    chk1("coin_err", e, 1'b0);
    step(2);

    // Back-to-back with req_valid held
    dev_delay = 2; dev_rdata = 32'h0000_0011; strobes.delete();
    bus.req_r_nw = 1'b1; bus.req_did = SPAM_DID_UART; bus.req_addr = 24'h000040;
    bus.req_valid = 1'b1;
    begin
      int k = 0;
      for (int i = 0; i < 60 && k < 3; i++) begin
        @(negedge clk);
        if (bus.req_ready) begin
          acc[k] = cyc;
          k++;
        end
      end
      if (k < 3) chk("b2b_accepts", 32'(k), 32'd3);
    end
    step(1);
    bus.req_valid = 1'b0;
    wait_rsp(m, d, e);
    chk("b2b_strobe_cnt", 32'(strobes.size()), 32'd3);
    if (strobes.size() >= 3) begin
      chk("b2b_strobe0", strobes[0], acc[0] + 1);
      chk("b2b_strobe1", strobes[1], acc[0] + 6);
      chk("b2b_strobe2", strobes[2], acc[0] + 11);
    end
    step(2);

    // Reset two cycles after the strobe, device answers afterwards
    dev_delay = 0;
    issue(1'b1, SPAM_DID_SACE, 24'h000010, 32'h0, n);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_ready", bus.req_ready, 1'b1);
    chk1("rst_spamo_valid", bus.spamo_valid, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_stray", bus.stray_rsp, 1'b0);
    step(1);
    rsp_cnt = 0;
    man_data = 32'h0000_1234; man_req = 1'b1;
    step(6);
    @(negedge clk);
    chk1("rst_late_stray", bus.stray_rsp, 1'b1);
    chk("rst_no_rsp", 32'(rsp_cnt), 32'd0);
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
